// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction-memory boot
//                controller: state encoding, memory geometry, zero word.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Default memory geometry: DEPTH words, AW = log2(DEPTH) word-address bits
    localparam int          DEPTH     = 256;
    localparam int          AW        = 8;

    // Value returned to the core whenever no valid instruction can be supplied
    localparam logic [31:0] IMEM_ZERO = 32'h0000_0000;

    // LOAD: program download in progress, core stalled; RUN: core fetching
    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_ctrl_if
//  Description : Loader stream, reload request and core fetch signals of the
//                instruction-memory boot controller, bundled in one interface.
//                "master" is the loader/core side, "slave" is the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_boot_ctrl_if #(
    parameter int AW = 8
) ();

    // Loader stream
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_ready;

    // Download control
    logic          reload_req;

    // Core fetch port
    logic [31:0]   fetch_addr;
    logic [31:0]   fetch_instr;
    logic          addr_err;
    logic          cpu_hold;

    // Status
    logic [AW:0]   load_count;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready,
        output reload_req,
        output fetch_addr,
        input  fetch_instr,
        input  addr_err,
        input  cpu_hold,
        input  load_count
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready,
        input  reload_req,
        input  fetch_addr,
        output fetch_instr,
        output addr_err,
        output cpu_hold,
        output load_count
    );

endinterface : imem_boot_ctrl_if
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ram
//  Description : Instruction storage. One synchronous write port and one
//                asynchronous read port. Contents are never cleared, so a
//                reset leaves the previously downloaded program intact.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  wire logic            clk,
    input  wire logic            we,
    input  wire logic [AW-1:0]   waddr,
    input  wire logic [31:0]     wdata,
    input  wire logic [AW-1:0]   raddr,
    output logic      [31:0]     rdata
);

    logic [31:0] r_mem [DEPTH];

    // Write the offered word on the clock edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Zero-latency read path for the core fetch
    always_comb begin
        rdata = r_mem[raddr];
    end

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_ctrl
//  Description : Boot controller for the core instruction memory. In LOAD it
//                accepts a program word stream from the loader while holding
//                the core; in RUN it serves combinational instruction fetches
//                and flags misaligned or out-of-range addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_ctrl #(
    parameter int DEPTH = imem_pkg::DEPTH,
    parameter int AW    = imem_pkg::AW
) (
    input  wire logic          clk,
    input  wire logic          rst,
    imem_boot_ctrl_if.slave    bus
);

    import imem_pkg::*;

    // Count value held just before the final (DEPTH-th) word is accepted
    localparam logic [AW:0]   c_LAST_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   c_CNT_INC  = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_INC  = AW'(1);

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_load_count;
    logic            r_ld_ready;
    logic            r_cpu_hold;

    logic            w_hs;
    logic            w_we;
    logic            w_full;
    logic            w_done;
    logic [AW-1:0]   w_raddr;
    logic [31:0]     w_rdata;
    logic            w_addr_err;

    // Handshake decode; a reset edge suppresses the write even with valid high
    always_comb begin
        w_hs   = bus.ld_valid & r_ld_ready;
        w_we   = w_hs & ~rst;
        w_full = (r_load_count == c_LAST_CNT);
        w_done = bus.ld_last | w_full;
    end

    // LOAD/RUN controller with write pointer, word counter and registered
    // hold/ready outputs; the pointer stops at the top word so it never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LOAD;
            r_wr_ptr     <= '0;
            r_load_count <= '0;
            r_ld_ready   <= 1'b1;
            r_cpu_hold   <= 1'b1;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_hs) begin
                        r_load_count <= r_load_count + c_CNT_INC;
                        if (!w_full) begin
                            r_wr_ptr <= r_wr_ptr + c_PTR_INC;
                        end
                        if (w_done) begin
                            r_state    <= RUN;
                            r_ld_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (bus.reload_req) begin
                        r_state      <= LOAD;
                        r_wr_ptr     <= '0;
                        r_load_count <= '0;
                        r_ld_ready   <= 1'b1;
                        r_cpu_hold   <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= LOAD;
                    r_ld_ready <= 1'b1;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (bus.ld_data),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    // Fetch address decode: word index plus alignment/range check
    always_comb begin
        w_raddr    = bus.fetch_addr[AW+1:2];
        w_addr_err = (bus.fetch_addr[1:0] != 2'b00) |
                     (bus.fetch_addr[31:AW+2] != '0);
    end

    // Output muxing: instructions only leave the block in RUN on a legal address
    always_comb begin
        bus.ld_ready    = r_ld_ready;
        bus.cpu_hold    = r_cpu_hold;
        bus.load_count  = r_load_count;
        bus.addr_err    = w_addr_err;
        bus.fetch_instr = ((r_state == RUN) && !w_addr_err) ? w_rdata : IMEM_ZERO;
    end

endmodule : imem_boot_ctrl
`default_nettype wire
